// File: rtl/puf_nist_scheduler.sv
// puf_nist_scheduler
//   Shares one NIST randomness-test block across N_PUF PUF response streams.
//   For each PUF in turn the block is reset (FLUSH), fed N_ROUNDS rounds of
//   ROUND_BITS response bits (STREAM), and the per-round pass vector is added
//   into eight pass counters (SAMPLE). The counters are then written to result
//   memory (STORE, 8 cycles).
//
// Ports
//   clk_1        clock
//   rst          synchronous active-high reset
//   start        begin a campaign (honoured in IDLE / DONE only)
//   resp         one response bit per PUF per cycle
//   test_result  NIST per-test pass flags, sampled at the end of SAMPLE
//   test_data    registered selected response bit to the NIST block
//   test_rst     NIST synchronous reset, one cycle per PUF
//   puf_sel      index of the PUF under test
//   mem_we       result write strobe
//   mem_waddr    result address, puf_sel*8 + test index
//   mem_din      pass count for that test
//   busy         campaign in progress
//   done         campaign complete, held until the next start
module puf_nist_scheduler #(
    parameter int N_PUF      = 4,
    parameter int ROUND_BITS = 20000,
    parameter int N_ROUNDS   = 255,
    parameter int AW         = 13
) (
    input  logic             clk_1,
    input  logic             rst,
    input  logic             start,
    input  logic [N_PUF-1:0] resp,
    input  logic [7:0]       test_result,
    output logic             test_data,
    output logic             test_rst,
    output logic [2:0]       puf_sel,
    output logic             mem_we,
    output logic [AW-1:0]    mem_waddr,
    output logic [7:0]       mem_din,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, FLUSH, STREAM, SAMPLE, STORE, DONE} state_t;

    localparam logic [15:0] LAST_BIT   = 16'(ROUND_BITS - 1);
    localparam logic [7:0]  LAST_ROUND = 8'(N_ROUNDS - 1);
    localparam logic [2:0]  LAST_PUF   = 3'(N_PUF - 1);

    state_t          state, state_n;
    logic [7:0][7:0] cnt, cnt_n, cnt_sum;
    logic [15:0]     bit_cnt, bit_cnt_n;
    logic [7:0]      round_cnt, round_cnt_n;
    logic [2:0]      test_idx, test_idx_n, puf_sel_n;
    logic            busy_n, done_n;
    logic            test_data_n, test_rst_n, mem_we_n;
    logic [AW-1:0]   mem_waddr_n;
    logic [7:0]      mem_din_n;
    logic [7:0]      resp_pad;

    // Widen so a 3-bit puf_sel can index any legal N_PUF.
    assign resp_pad = 8'(resp);

    // One accumulator lane per NIST test.
    for (genvar g = 0; g < 8; g++) begin : g_acc
        assign cnt_sum[g] = cnt[g] + {7'd0, test_result[g]};
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_cnt_n   = bit_cnt;
        round_cnt_n = round_cnt;
        test_idx_n  = test_idx;
        puf_sel_n   = puf_sel;
        busy_n      = busy;
        done_n      = done;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    puf_sel_n   = 3'd0;
                    busy_n      = 1'b1;
                    done_n      = 1'b0;
                    cnt_n       = '0;
                    bit_cnt_n   = '0;
                    round_cnt_n = '0;
                    test_idx_n  = '0;
                    state_n     = FLUSH;
                end
            end
            FLUSH: state_n = STREAM;
            STREAM: begin
                bit_cnt_n = bit_cnt + 16'd1;
                if (bit_cnt == LAST_BIT) state_n = SAMPLE;
            end
            SAMPLE: begin
                cnt_n       = cnt_sum;
                bit_cnt_n   = '0;
                round_cnt_n = round_cnt + 8'd1;
                state_n     = (round_cnt == LAST_ROUND) ? STORE : STREAM;
            end
            STORE: begin
                test_idx_n = test_idx + 3'd1;
                if (test_idx == 3'd7) begin
                    if (puf_sel == LAST_PUF) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        puf_sel_n   = puf_sel + 3'd1;
                        cnt_n       = '0;
                        round_cnt_n = '0;
                        state_n     = FLUSH;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered from the next state so that they line up
        // with the state they describe (e.g. the first FLUSH cycle already
        // carries the new PUF's bit, and mem_din sees the final SAMPLE add).
        test_rst_n  = (state_n == FLUSH);
        mem_we_n    = (state_n == STORE);
        mem_waddr_n = (state_n == STORE) ? AW'({puf_sel_n, test_idx_n}) : '0;
        mem_din_n   = (state_n == STORE) ? cnt_n[test_idx_n] : 8'd0;
        test_data_n = (state_n != IDLE && state_n != DONE) ? resp_pad[puf_sel_n] : 1'b0;
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            round_cnt <= '0;
            test_idx  <= '0;
            puf_sel   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            test_data <= 1'b0;
            test_rst  <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_din   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_cnt_n;
            round_cnt <= round_cnt_n;
            test_idx  <= test_idx_n;
            puf_sel   <= puf_sel_n;
            busy      <= busy_n;
            done      <= done_n;
            test_data <= test_data_n;
            test_rst  <= test_rst_n;
            mem_we    <= mem_we_n;
            mem_waddr <= mem_waddr_n;
            mem_din   <= mem_din_n;
        end
    end

endmodule

// File: tb/tb_puf_nist_scheduler.sv
// Bench for puf_nist_scheduler: two instances (2 PUF x 3 rounds x 16 bits,
// and 1 PUF x 1 round x 2 bits). Expected memory writes are queued when a
// campaign is launched and checked by monitors; per-cycle control outputs
// are compared against cycle positions derived from the round/PUF timing.
module tb_puf_nist_scheduler;

    localparam int NA    = 2;
    localparam int RBA   = 16;
    localparam int NRA   = 3;
    localparam int PERA  = 1 + NRA * (RBA + 1) + 8;
    localparam int CAMPA = NA * PERA;
    localparam int CAMPB = 12;

    logic clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  resp_a = '0;
    logic [0:0]  resp_b = '0;
    logic [7:0]  tres_a = '0, tres_b = '0;

    logic        td_a, trst_a, we_a, busy_a, done_a;
    logic [2:0]  sel_a;
    logic [12:0] addr_a;
    logic [7:0]  din_a;
    logic        td_b, trst_b, we_b, busy_b, done_b;
    logic [2:0]  sel_b;
    logic [12:0] addr_b;
    logic [7:0]  din_b;

    puf_nist_scheduler #(.N_PUF(NA), .ROUND_BITS(RBA), .N_ROUNDS(NRA), .AW(13)) dut_a (
        .clk_1(clk_1), .rst(rst), .start(start_a), .resp(resp_a), .test_result(tres_a),
        .test_data(td_a), .test_rst(trst_a), .puf_sel(sel_a), .mem_we(we_a),
        .mem_waddr(addr_a), .mem_din(din_a), .busy(busy_a), .done(done_a));

    puf_nist_scheduler #(.N_PUF(1), .ROUND_BITS(2), .N_ROUNDS(1), .AW(13)) dut_b (
        .clk_1(clk_1), .rst(rst), .start(start_b), .resp(resp_b), .test_result(tres_b),
        .test_data(td_b), .test_rst(trst_b), .puf_sel(sel_b), .mem_we(we_b),
        .mem_waddr(addr_b), .mem_din(din_b), .busy(busy_b), .done(done_b));

    typedef struct {int addr; int data;} wr_t;
    wr_t qa[$];
    wr_t qb[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Write monitors: every strobe must match the oldest expected write.
    always @(negedge clk_1) begin : mon_a
        wr_t w;
        if (we_a) begin
            if (qa.size() == 0) chk("a_unexpected_write", 1, 0);
            else begin
                w = qa.pop_front();
                chk("a_waddr", int'(addr_a), w.addr);
                chk("a_wdata", int'(din_a), w.data);
            end
        end
    end

    always @(negedge clk_1) begin : mon_b
        wr_t w;
        if (we_b) begin
            if (qb.size() == 0) chk("b_unexpected_write", 1, 0);
            else begin
                w = qb.pop_front();
                chk("b_waddr", int'(addr_b), w.addr);
                chk("b_wdata", int'(din_b), w.data);
            end
        end
    end

    task automatic check_idle_a();
        chk("a_idle_test_data", int'(td_a), 0);
        chk("a_idle_test_rst", int'(trst_a), 0);
        chk("a_idle_puf_sel", int'(sel_a), 0);
        chk("a_idle_mem_we", int'(we_a), 0);
        chk("a_idle_waddr", int'(addr_a), 0);
        chk("a_idle_din", int'(din_a), 0);
        chk("a_idle_busy", int'(busy_a), 0);
        chk("a_idle_done", int'(done_a), 0);
    endtask

    // mode 0: random pass vectors and responses; 1: all-pass; 2: 05/00/05
    // pass pattern with resp fixed at 2'b10. inj: cycle to pulse start while
    // busy (-1 none). rst_at: cycle in which reset is raised (-1 none).
    task automatic run_a(input int mode, input int inj, input int rst_at);
        logic [7:0] tr [NA][NRA];
        int c, p, u;
        bit live;
        for (int pp = 0; pp < NA; pp++)
            for (int r = 0; r < NRA; r++)
                tr[pp][r] = (mode == 1) ? 8'hFF :
                            (mode == 2) ? ((r == 1) ? 8'h00 : 8'h05) : 8'($urandom);
        for (int pp = 0; pp < NA; pp++)
            for (int i = 0; i < 8; i++) begin
                c = 0;
                for (int r = 0; r < NRA; r++) c += int'(tr[pp][r][i]);
                qa.push_back('{pp * 8 + i, c});
            end

        @(negedge clk_1);
        start_a = 1'b1;
        resp_a  = (mode == 2) ? 2'b10 : 2'($urandom);
        tres_a  = 8'($urandom);
        for (int t = 0; t < CAMPA + 6; t++) begin
            @(negedge clk_1);
            p    = t / PERA;
            u    = t % PERA;
            live = (t < CAMPA);
            if (rst_at >= 0 && t > rst_at) check_idle_a();
            else begin
                chk("a_busy", int'(busy_a), int'(live));
                chk("a_done", int'(done_a), int'(!live));
                chk("a_test_rst", int'(trst_a), int'(live && u == 0));
                chk("a_puf_sel", int'(sel_a), live ? p : NA - 1);
                chk("a_mem_we", int'(we_a), int'(live && u >= PERA - 8));
                chk("a_test_data", int'(td_a), live ? int'(resp_a[p]) : 0);
            end
            start_a = (t == inj);
            rst     = (rst_at >= 0) && (t == rst_at || t == rst_at + 1);
            resp_a  = (mode == 2) ? 2'b10 : 2'($urandom);
            tres_a  = 8'($urandom);
            if (live && u >= 1 && u <= NRA * (RBA + 1) && (u - 1) % (RBA + 1) == RBA)
                tres_a = tr[p][(u - 1) / (RBA + 1)];
        end
        if (rst_at >= 0) begin
            chk("a_pending_after_rst", qa.size(), 16 - (rst_at - (PERA - 8) + 1));
            qa.delete();
        end else chk("a_pending", qa.size(), 0);
    endtask

    task automatic run_b(input int was_done);
        logic [7:0] tr;
        tr = 8'($urandom);
        for (int i = 0; i < 8; i++) qb.push_back('{i, int'(tr[i])});
        @(negedge clk_1);
        chk("b_done_before_start", int'(done_b), was_done);
        start_b = 1'b1;
        resp_b  = 1'($urandom);
        tres_b  = 8'($urandom);
        for (int t = 0; t < CAMPB + 2; t++) begin
            @(negedge clk_1);
            chk("b_busy", int'(busy_b), int'(t < CAMPB));
            chk("b_done", int'(done_b), int'(t >= CAMPB));
            chk("b_test_rst", int'(trst_b), int'(t == 0));
            chk("b_mem_we", int'(we_b), int'(t >= 4 && t < CAMPB));
            chk("b_test_data", int'(td_b), (t < CAMPB) ? int'(resp_b[0]) : 0);
            start_b = 1'b0;
            resp_b  = 1'($urandom);
            tres_b  = (t == 3) ? tr : 8'($urandom);
        end
        chk("b_pending", qb.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_1);
        check_idle_a();
        chk("b_rst_busy", int'(busy_b), 0);
        chk("b_rst_done", int'(done_b), 0);
        chk("b_rst_we", int'(we_b), 0);
        rst = 1'b0;
        @(negedge clk_1);
        check_idle_a();

        run_a(1, -1, -1);   // all-pass: counts of NRA everywhere
        run_a(2, -1, -1);   // 05/00/05 pattern, resp 2'b10
        run_a(0, -1, -1);   // random
        run_a(1, 25, -1);   // start pulse mid-stream is ignored
        run_a(0, -1, PERA - 5);  // reset at STORE index 3 of PUF0
        run_a(1, -1, -1);   // fresh campaign after reset
        run_b(0);
        run_b(1);           // restart straight from DONE

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/puf_nist_scheduler.md
# puf_nist_scheduler

Time-multiplexes one NIST randomness-test block across `N_PUF` PUF response streams on the `clk_1` domain. For each PUF in turn it:
- resets the test block and streams `N_ROUNDS` rounds of `ROUND_BITS` response bits into it;
- accumulates the per-round 8-bit pass vector into eight pass counters;
- writes the eight counters to result memory.

It sits between the PUF instances and the shared NIST block and result-memory write port, replacing a single-PUF fixed test FSM.

## Interface
- `N_PUF`, default 4: number of PUF streams; 1..8.
- `ROUND_BITS`, default 20000: STREAM cycles per test round; 2..32767.
- `N_ROUNDS`, default 255: rounds per PUF; 1..255, so counters never overflow.
- `AW`, default 13: memory address width.

Ports:
- `clk_1` in 1: clock.
- `rst` in 1: synchronous, active-high reset; clock `clk_1`.
- `start` in 1: begin a full campaign; sampled in IDLE or DONE only.
- `resp` in `N_PUF`: one response bit per PUF per cycle.
- `test_result` in 8: NIST per-test pass flags, valid at round end.
- `test_data` out 1: registered selected response bit to NIST.
- `test_rst` out 1: NIST synchronous reset, high one cycle per PUF.
- `puf_sel` out 3: index of the PUF currently under test.
- `mem_we` out 1: result write strobe.
- `mem_waddr` out `AW`: result address.
- `mem_din` out 8: pass count.
- `busy` out 1: campaign in progress.
- `done` out 1: campaign complete, held until next start.

## Operation
- States: IDLE, FLUSH, STREAM, SAMPLE, STORE, DONE. All outputs are registered.
- **IDLE / DONE, start=1:**
  - `puf_sel`←0, `busy`←1, `done`←0.
  - Clear counters `cnt0..cnt7`, `bit_cnt`, `round_cnt`, `test_idx`.
  - Go to FLUSH.
- **FLUSH:** `test_rst`←1 for exactly this cycle, then → STREAM.
- **STREAM:** `bit_cnt`++ each cycle. When `bit_cnt==ROUND_BITS-1` → SAMPLE.
- **SAMPLE:**
  - `cnt[i]` += `test_result[i]` for i=0..7, using 8-bit adds.
  - `bit_cnt`←0, `round_cnt`++.
  - If `round_cnt==N_ROUNDS-1` → STORE, else → STREAM.
- **STORE (8 cycles, `test_idx` 0..7):**
  - `mem_we`=1.
  - `mem_waddr` = `puf_sel*8 + test_idx`.
  - `mem_din` = `cnt[test_idx]`.
  - After `test_idx==7`:
    - If `puf_sel==N_PUF-1` → DONE (`busy`←0, `done`←1).
    - Else `puf_sel`++, clear counters and `round_cnt`, → FLUSH.
- **DONE:** hold all counters and `done`=1. Only `start` leaves this state.
- **`test_data` source:**
  - `test_data` ← `resp[puf_sel]` every cycle in FLUSH, STREAM, SAMPLE and STORE.
  - `test_data` ← 0 in IDLE and DONE.
  - The NIST block keeps clocking through SAMPLE and STORE. Those bits are discarded by the next FLUSH or by round alignment.
- `start` is ignored while `busy`=1.
- **Reset (any time, including mid-round or mid-STORE):**
  - State ← IDLE.
  - All outputs ← 0: `test_data`, `test_rst`, `puf_sel`, `mem_we`, `mem_waddr`, `mem_din`, `busy`, `done`.
  - All counters ← 0.
  - No partial write completes after the reset edge.

## Timing
- A round is `ROUND_BITS` STREAM cycles plus 1 SAMPLE cycle.
- `test_result` is sampled at the clock edge that ends the SAMPLE cycle.
- Per-PUF cycle count: 1 + `N_ROUNDS*(ROUND_BITS+1)` + 8.
- Campaign length: `N_PUF` × the per-PUF cycle count.
- Start → first `test_rst`: `test_rst` goes high 1 cycle after the edge that samples `start`.
- Start → `done`:
  - `done` rises exactly campaign-length cycles after the start edge.
  - `busy` falls on the same edge as `done` rises.
- `mem_we` is high for exactly 8 consecutive cycles per PUF, with address and data valid in the same cycle.
- `puf_sel` changes on the edge entering FLUSH, so the first FLUSH-cycle `test_data` is already from the new PUF.

## Test plan
- Use `N_PUF`=2, `ROUND_BITS`=16, `N_ROUNDS`=3 for all scenarios unless noted.
1. `test_result`=8'hFF constant, single start pulse:
   - 16 writes, addr 0..15, data 3 each.
   - `test_rst` pulses twice, 60 cycles apart.
   - `done` rises 120 cycles after the start edge.
2. `test_result`=8'h05 in rounds 0 and 2, 8'h00 in round 1:
   - PUF0 writes 2,0,2,0,0,0,0,0 to addr 0..7.
   - PUF1 writes the same to addr 8..15.
3. `resp`=2'b10 constant: `test_data` is 0 during PUF0 STREAM and 1 during PUF1 STREAM.
4. Pulse `start` during STREAM of PUF0 round 1: no restart; write count and `done` timing identical to scenario 1.
5. Assert `rst` at STORE `test_idx`=3 of PUF0:
   - From the next edge, all outputs are 0 and `mem_we` stays 0.
   - A fresh start reproduces scenario 1 exactly.
6. `N_PUF`=1, `N_ROUNDS`=1, `ROUND_BITS`=2:
   - Campaign is 1+3+8=12 cycles.
   - `done`=1 12 cycles after start; a second start while `done`=1 restarts, `done`→0 the next cycle.
